// File: rtl/avg_pool_pkg.sv
// Shared constants and width helpers for the streaming average pooler.
package avg_pool_pkg;

  // Rounding modes applied before the final divide-by-window-area shift.
  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Ceiling log2; returns 0 for an argument of 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Address/counter width that never collapses to zero bits.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // Horizontal accumulator: K samples summed.
  function automatic int acc_w(input int data_w, input int k);
    return data_w + clog2(k);
  endfunction

  // Line buffer entry: K*K samples summed.
  function automatic int lb_w(input int data_w, input int k);
    return data_w + 2 * clog2(k);
  endfunction

  // Right shift that divides a full window sum by K*K.
  function automatic int shift_of(input int k);
    return 2 * clog2(k);
  endfunction

endpackage

// File: rtl/avg_pool_line_buf.sv
// Register file holding one partial vertical sum per window column.
// Combinational read, synchronous write; reading and writing the same
// address in one cycle gives a read-modify-write (old value read, new written).
module avg_pool_line_buf
  import avg_pool_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 10,
  localparam int AW   = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[rd_addr];

  // Write port: contents need no reset, row%K==0 always overwrites first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/avg_pool2d_stream.sv
// Streaming KxK, stride-K average pooling over a raster-scan frame.
// Pixels are summed horizontally in per-channel accumulators, completed
// horizontal sums are folded into a line buffer row by row, and the last
// row of each window produces the pooled pixel into a one-deep output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid, once raised, holds with its data stable until the transfer;
// ready may change freely. in_ready = !rst && (!out_valid || out_ready), so a
// pixel is only accepted when the output register is free or being drained in
// the same cycle, which lets back-to-back pixels stream at one per cycle.
module avg_pool2d_stream
  import avg_pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K      = 2,
  parameter int ROUND  = ROUND_TRUNC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last,
  output logic                 frame_err
);

  localparam int LK    = clog2(K);
  localparam int SHIFT = shift_of(K);
  localparam int ACC_W = acc_w(DATA_W, K);
  localparam int LB_W  = lb_w(DATA_W, K);
  localparam int NWIN  = IMG_W / K;
  localparam int CW    = idx_w(IMG_W);
  localparam int RW    = idx_w(IMG_H);
  localparam int WCW   = idx_w(NWIN);

  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);
  localparam logic [LK-1:0]   PH_LAST  = LK'(K - 1);
  localparam logic [LB_W-1:0] RND      = (ROUND == ROUND_HALF_UP) ?
                                         (LB_W'(1) << (SHIFT - 1)) : '0;

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [LK-1:0]        col_ph;
  logic [LK-1:0]        row_ph;
  logic [WCW-1:0]       wc;
  logic                 accept;
  logic                 at_end;
  logic                 early_last;
  logic                 win_col_end;
  logic                 emit;
  logic                 lb_we;
  logic [CH*LB_W-1:0]   lb_rd;
  logic [CH*LB_W-1:0]   lb_wr;
  logic [CH*DATA_W-1:0] pooled;

  assign in_ready    = !rst && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign col_ph      = col[LK-1:0];
  assign row_ph      = row[LK-1:0];
  assign wc          = WCW'(col >> LK);
  assign at_end      = (row == ROW_LAST) && (col == COL_LAST);
  // in_last before the final position abandons the frame: no write, no emit.
  assign early_last  = in_last && !at_end;
  assign win_col_end = (col_ph == PH_LAST);
  assign emit        = accept && !early_last && win_col_end && (row_ph == PH_LAST);
  assign lb_we       = accept && !early_last && win_col_end && (row_ph != PH_LAST);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DATA_W-1:0] pix;
    logic [ACC_W-1:0]  hacc;
    logic [ACC_W-1:0]  hsum;
    logic [LB_W-1:0]   lb_old;
    logic [LB_W-1:0]   lb_sum;
    logic [LB_W-1:0]   emit_sum;

    assign pix      = in_data[c*DATA_W +: DATA_W];
    assign hsum     = hacc + ACC_W'(pix);
    assign lb_old   = lb_rd[c*LB_W +: LB_W];
    assign lb_sum   = lb_old + LB_W'(hsum);
    assign emit_sum = lb_sum + RND;
    // First row of a window band starts the vertical sum, later rows add to it.
    assign lb_wr[c*LB_W +: LB_W]       = (row_ph == '0) ? LB_W'(hsum) : lb_sum;
    assign pooled[c*DATA_W +: DATA_W]  = DATA_W'(emit_sum >> SHIFT);

    // Horizontal accumulator restarts at the first column of each window.
    always_ff @(posedge clk) begin
      if (accept) begin
        hacc <= (col_ph == '0) ? ACC_W'(pix) : hsum;
      end
    end
  end

  avg_pool_line_buf #(
    .DEPTH (NWIN),
    .WIDTH (CH * LB_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (wc),
    .wr_data (lb_wr),
    .rd_addr (wc),
    .rd_data (lb_rd)
  );

  // Raster position counters; an early in_last restarts the frame at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (early_last) begin
        col <= '0;
        row <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Output register: load on emit, clear on drain, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= pooled;
      out_last  <= at_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // One-cycle flag when in_last disagrees with the final frame position.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && (in_last != at_end);
    end
  end

endmodule

// File: tb/tb_avg_pool2d_stream.sv
// Bench for avg_pool2d_stream: a 4x4/K=2 pair (truncate and round-half-up,
// sharing inputs) and an 8x4/K=4/CH=3 instance, checked against a window-sum model.
module tb_avg_pool2d_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // 4x4 pair (shared inputs)
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       a_in_ready, a_out_valid, a_out_last, a_frame_err;
  logic [7:0] a_out_data;
  logic       r_in_ready, r_out_valid, r_out_last, r_frame_err;
  logic [7:0] r_out_data;
  // 8x4, K=4, 3 channels
  logic        b_in_valid, b_in_last, b_out_ready;
  logic [23:0] b_in_data;
  logic        b_in_ready, b_out_valid, b_out_last, b_frame_err;
  logic [23:0] b_out_data;

  avg_pool2d_stream #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .K(2), .ROUND(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .frame_err(a_frame_err));

  avg_pool2d_stream #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .K(2), .ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_last(r_out_last), .frame_err(r_frame_err));

  avg_pool2d_stream #(.DATA_W(8), .CH(3), .IMG_W(8), .IMG_H(4), .K(4), .ROUND(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .frame_err(b_frame_err));

  // ---------------- scoreboard state ----------------
  logic [8:0]  exp_a_q[$], exp_r_q[$], got_a_q[$], got_r_q[$];
  logic [24:0] exp_b_q[$], got_b_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ferr_a = 0, ferr_r = 0, ferr_b = 0;
  int   frm [16];
  int   frm_b [32][3];
  logic rnd_ready = 1'b0;

  // Output monitor: a transfer is recorded on the half-cycle before its edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && out_ready)   got_a_q.push_back({a_out_last, a_out_data});
      if (r_out_valid && out_ready)   got_r_q.push_back({r_out_last, r_out_data});
      if (b_out_valid && b_out_ready) got_b_q.push_back({b_out_last, b_out_data});
      if (a_frame_err) ferr_a++;
      if (r_frame_err) ferr_r++;
      if (b_frame_err) ferr_b++;
    end
  end

  // ---------------- reference model ----------------
  // Average of each 2x2 window of frm, windows in raster order.
  task automatic model_a();
    for (int wy = 0; wy < 2; wy++) begin
      for (int wx = 0; wx < 2; wx++) begin
        int s;
        logic lw;
        s = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            s += frm[(2*wy + dy)*4 + 2*wx + dx];
        lw = (wy == 1) && (wx == 1);
        exp_a_q.push_back({lw, 8'(s / 4)});
        exp_r_q.push_back({lw, 8'((s + 2) / 4)});
      end
    end
  endtask

  // Rounded average of each 4x4 window of frm_b, per channel.
  task automatic model_b();
    for (int wx = 0; wx < 2; wx++) begin
      logic [23:0] v;
      v = '0;
      for (int ch = 0; ch < 3; ch++) begin
        int s;
        s = 0;
        for (int dy = 0; dy < 4; dy++)
          for (int dx = 0; dx < 4; dx++)
            s += frm_b[dy*8 + wx*4 + dx][ch];
        v[ch*8 +: 8] = 8'((s + 8) / 16);
      end
      exp_b_q.push_back({(wx == 1), v});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!a_in_ready && waited < 100) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      waited++;
    end
    if (!a_in_ready) begin
      n_vec++; n_err++;
      $display("FAIL a_accept_timeout: in_ready stayed %0b, required 1", a_in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_b(input logic [23:0] d, input logic last);
    int waited;
    waited = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
    @(negedge clk);
    while (!b_in_ready && waited < 100) begin
      @(posedge clk); #1;
      if (rnd_ready) b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      waited++;
    end
    if (!b_in_ready) begin
      n_vec++; n_err++;
      $display("FAIL b_accept_timeout: in_ready stayed %0b, required 1", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    if (rnd_ready) b_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame_a(input logic final_last);
    for (int i = 0; i < 16; i++) drive_a(8'(frm[i]), (i == 15) ? final_last : 1'b0);
  endtask

  task automatic random_frame_a();
    for (int i = 0; i < 16; i++) frm[i] = $urandom_range(0, 255);
  endtask

  task automatic load_case1();
    for (int i = 0; i < 16; i++) frm[i] = 4 * (i + 1);
  endtask

  task automatic drain();
    rnd_ready = 1'b0; out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b required 0", a_out_valid); end
    n_vec++; if (a_out_data !== 8'd0) begin n_err++; $display("FAIL reset_out_data: got %0d required 0", a_out_data); end
    n_vec++; if (a_out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %0b required 0", a_out_last); end
    n_vec++; if (a_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %0b required 0", a_frame_err); end
    n_vec++; if (a_in_ready !== 1'b0 || r_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %0b%0b%0b required 000", a_in_ready, r_in_ready, b_in_ready);
    end
    n_vec++; if (b_out_valid !== 1'b0 || b_out_data !== 24'd0) begin
      n_err++; $display("FAIL reset_b_out: got valid=%0b data=%h required 0/0", b_out_valid, b_out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %0b required 1", a_in_ready); end
    @(posedge clk); #1;
  endtask

  // Compares both 4x4 instances' collected outputs against the scoreboard.
  task automatic test_directed();
    logic [8:0] g, e;
    load_case1();
    exp_a_q = '{9'd14, 9'd22, 9'd46, {1'b1, 8'd54}};
    exp_r_q = '{9'd14, 9'd22, 9'd46, {1'b1, 8'd54}};
    send_frame_a(1'b1);
    drain();
    n_vec++;
    if (got_a_q.size() != 4 || got_r_q.size() != 4) begin
      n_err++; $display("FAIL directed_count: got %0d/%0d outputs required 4/4", got_a_q.size(), got_r_q.size());
    end
    while (got_a_q.size() > 0 && exp_a_q.size() > 0) begin
      g = got_a_q.pop_front(); e = exp_a_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL directed_trunc: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    while (got_r_q.size() > 0 && exp_r_q.size() > 0) begin
      g = got_r_q.pop_front(); e = exp_r_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL directed_round: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    got_a_q.delete(); got_r_q.delete(); exp_a_q.delete(); exp_r_q.delete();
  endtask

  task automatic test_round();
    logic [8:0] g;
    random_frame_a();
    frm[0] = 1; frm[1] = 2; frm[4] = 2; frm[5] = 2;
    frm[2] = 255; frm[3] = 255; frm[6] = 255; frm[7] = 255;
    send_frame_a(1'b1);
    drain();
    n_vec++;
    if (got_a_q.size() != 4 || got_r_q.size() != 4) begin
      n_err++; $display("FAIL round_count: got %0d/%0d outputs required 4/4", got_a_q.size(), got_r_q.size());
    end else begin
      g = got_a_q[0]; n_vec++;
      if (g[7:0] !== 8'd1) begin n_err++; $display("FAIL round_trunc_small: got %0d required 1", g[7:0]); end
      g = got_r_q[0]; n_vec++;
      if (g[7:0] !== 8'd2) begin n_err++; $display("FAIL round_half_up_small: got %0d required 2", g[7:0]); end
      g = got_a_q[1]; n_vec++;
      if (g[7:0] !== 8'd255) begin n_err++; $display("FAIL round_trunc_max: got %0d required 255", g[7:0]); end
      g = got_r_q[1]; n_vec++;
      if (g[7:0] !== 8'd255) begin n_err++; $display("FAIL round_half_up_max: got %0d required 255", g[7:0]); end
    end
    got_a_q.delete(); got_r_q.delete();
  endtask

  task automatic test_backpressure();
    logic [8:0] g, e, held;
    random_frame_a();
    model_a();
    held = exp_a_q[0];
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive_a(8'(frm[i]), 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'(frm[6]); in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %0b required 1", a_out_valid); end
      n_vec++; if (a_out_data !== held[7:0]) begin n_err++; $display("FAIL stall_data: got %0d required %0d", a_out_data, held[7:0]); end
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %0b required 0", a_in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 6; i < 16; i++) drive_a(8'(frm[i]), (i == 15));
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      random_frame_a();
      model_a();
      send_frame_a(1'b1);
    end
    drain();
    n_vec++;
    if (got_a_q.size() != exp_a_q.size() || got_r_q.size() != exp_r_q.size()) begin
      n_err++; $display("FAIL backpressure_count: got %0d/%0d outputs required %0d/%0d", got_a_q.size(), got_r_q.size(), exp_a_q.size(), exp_r_q.size());
    end
    while (got_a_q.size() > 0 && exp_a_q.size() > 0) begin
      g = got_a_q.pop_front(); e = exp_a_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL backpressure_trunc: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    while (got_r_q.size() > 0 && exp_r_q.size() > 0) begin
      g = got_r_q.pop_front(); e = exp_r_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL backpressure_round: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    got_a_q.delete(); got_r_q.delete(); exp_a_q.delete(); exp_r_q.delete();
  endtask

  task automatic test_frame_err();
    logic [8:0] g, e;
    int f0, r0;
    // in_last on pixel 9: only the two windows of rows 0-1 are emitted
    random_frame_a();
    model_a();
    void'(exp_a_q.pop_back()); void'(exp_a_q.pop_back());
    void'(exp_r_q.pop_back()); void'(exp_r_q.pop_back());
    f0 = ferr_a; r0 = ferr_r;
    for (int i = 0; i < 9; i++) drive_a(8'(frm[i]), (i == 8));
    drain();
    n_vec++; if (ferr_a - f0 != 1 || ferr_r - r0 != 1) begin
      n_err++; $display("FAIL early_last_pulse: got %0d/%0d pulses required 1/1", ferr_a - f0, ferr_r - r0);
    end
    // clean frame after the abort
    random_frame_a(); model_a();
    f0 = ferr_a;
    send_frame_a(1'b1);
    drain();
    n_vec++; if (ferr_a - f0 != 0) begin n_err++; $display("FAIL clean_frame_pulse: got %0d pulses required 0", ferr_a - f0); end
    // final pixel without in_last: flagged, still pooled and wrapped
    random_frame_a(); model_a();
    f0 = ferr_a;
    send_frame_a(1'b0);
    drain();
    n_vec++; if (ferr_a - f0 != 1) begin n_err++; $display("FAIL missing_last_pulse: got %0d pulses required 1", ferr_a - f0); end
    random_frame_a(); model_a();
    send_frame_a(1'b1);
    drain();
    n_vec++;
    if (got_a_q.size() != exp_a_q.size() || got_r_q.size() != exp_r_q.size()) begin
      n_err++; $display("FAIL frame_err_count: got %0d/%0d outputs required %0d/%0d", got_a_q.size(), got_r_q.size(), exp_a_q.size(), exp_r_q.size());
    end
    while (got_a_q.size() > 0 && exp_a_q.size() > 0) begin
      g = got_a_q.pop_front(); e = exp_a_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL frame_err_trunc: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    while (got_r_q.size() > 0 && exp_r_q.size() > 0) begin
      g = got_r_q.pop_front(); e = exp_r_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL frame_err_round: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    got_a_q.delete(); got_r_q.delete(); exp_a_q.delete(); exp_r_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [8:0] g, e;
    random_frame_a();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive_a(8'(frm[i]), 1'b0);
    out_ready = 1'b0;
    drive_a(8'(frm[5]), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_pending: got %0b required 1", a_out_valid); end
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_in_ready: got %0b required 0", a_in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_out_valid: got %0b required 0", a_out_valid); end
    @(posedge clk); #1;
    got_a_q.delete(); got_r_q.delete();
    out_ready = 1'b1;
    load_case1();
    exp_a_q = '{9'd14, 9'd22, 9'd46, {1'b1, 8'd54}};
    send_frame_a(1'b1);
    drain();
    n_vec++;
    if (got_a_q.size() != 4) begin n_err++; $display("FAIL after_reset_count: got %0d outputs required 4", got_a_q.size()); end
    while (got_a_q.size() > 0 && exp_a_q.size() > 0) begin
      g = got_a_q.pop_front(); e = exp_a_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL after_reset_out: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    got_a_q.delete(); got_r_q.delete(); exp_a_q.delete(); exp_r_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [8:0] g, e;
    int start;
    out_ready = 1'b1;
    random_frame_a(); model_a();
    start = cyc;
    send_frame_a(1'b1);
    n_vec++; if (cyc - start != 16) begin n_err++; $display("FAIL throughput: got %0d cycles for 16 pixels required 16", cyc - start); end
    random_frame_a(); model_a();
    send_frame_a(1'b1);
    drain();
    n_vec++;
    if (got_a_q.size() != exp_a_q.size()) begin
      n_err++; $display("FAIL back_to_back_count: got %0d outputs required %0d", got_a_q.size(), exp_a_q.size());
    end
    while (got_a_q.size() > 0 && exp_a_q.size() > 0) begin
      g = got_a_q.pop_front(); e = exp_a_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL back_to_back_out: got last=%0b data=%0d required last=%0b data=%0d", g[8], g[7:0], e[8], e[7:0]); end
    end
    got_a_q.delete(); got_r_q.delete(); exp_a_q.delete(); exp_r_q.delete();
  endtask

  task automatic test_wide();
    logic [24:0] g, e;
    logic [23:0] px;
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++)
        for (int ch = 0; ch < 3; ch++)
          frm_b[i][ch] = (f == 0) ? 255 : $urandom_range(0, 255);
      model_b();
      for (int i = 0; i < 32; i++) begin
        for (int ch = 0; ch < 3; ch++) px[ch*8 +: 8] = 8'(frm_b[i][ch]);
        drive_b(px, (i == 31));
      end
    end
    drain();
    n_vec++;
    if (got_b_q.size() != exp_b_q.size()) begin
      n_err++; $display("FAIL wide_count: got %0d outputs required %0d", got_b_q.size(), exp_b_q.size());
    end
    while (got_b_q.size() > 0 && exp_b_q.size() > 0) begin
      g = got_b_q.pop_front(); e = exp_b_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL wide_out: got last=%0b data=%h required last=%0b data=%h", g[24], g[23:0], e[24], e[23:0]); end
    end
    n_vec++; if (ferr_b != 0) begin n_err++; $display("FAIL wide_frame_err: got %0d pulses required 0", ferr_b); end
    got_b_q.delete(); exp_b_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_round();
    test_backpressure();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
